// File: rtl/robot_controller.sv
// Wall-following decision engine for the pipe-cleaning robot: seeks a wall, keeps it on the left,
// clears trash and stops on the exit cell. Optional step limit enabled by ROBOT_STEP_LIMIT_EN.
module robot_controller #(
    parameter int unsigned STEP_LIMIT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove,
    output logic halted
);

    typedef enum logic [3:0] {
        SEEK, FOLLOW, FWD_FORCE, TURN_L, ROT2, ROT3, REM1, REM2, HALT
    } state_e;

    state_e state_q, state_d, fwd_next;
    logic   resume_q, resume_d;    // 1: return to FOLLOW after removal, 0: return to SEEK
    logic   front_q, front_d;
    logic   turn_q, turn_d;
    logic   remove_q, remove_d;
    logic   halted_q, halted_d;
    logic   issue_fwd;
    logic   limit_hit;

`ifdef ROBOT_STEP_LIMIT_EN
    localparam int CNT_W = (STEP_LIMIT < 1) ? 1 : $clog2(STEP_LIMIT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The forward that brings the count to the limit is the last one issued.
    assign limit_hit = (cnt_q == CNT_W'(STEP_LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (front_d && (cnt_q != CNT_W'(STEP_LIMIT)))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_step_limit;
    assign unused_step_limit = ^STEP_LIMIT;
    assign limit_hit         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        front_d   = 1'b0;
        turn_d    = 1'b0;
        remove_d  = 1'b0;
        halted_d  = halted_q;
        issue_fwd = 1'b0;
        fwd_next  = state_q;
        case (state_q)
            SEEK, FOLLOW, FWD_FORCE: begin
                if (under) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (state_q == FOLLOW && !left) begin
                    turn_d  = 1'b1;
                    state_d = FWD_FORCE;
                end else if (barrier) begin
                    remove_d = 1'b1;
                    state_d  = REM1;
                    resume_d = (state_q != SEEK);
                end else if (head) begin
                    turn_d  = 1'b1;
                    state_d = ROT2;
                end else begin
                    issue_fwd = 1'b1;
                    fwd_next  = (state_q == SEEK) ? SEEK : FOLLOW;
                end
            end
            ROT2: begin
                turn_d  = 1'b1;
                state_d = ROT3;
            end
            ROT3: begin
                turn_d  = 1'b1;
                state_d = FOLLOW;
            end
            REM1: begin
                remove_d = 1'b1;
                state_d  = REM2;
            end
            REM2: begin
                remove_d = 1'b1;
                state_d  = resume_q ? FOLLOW : SEEK;
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = SEEK;
        endcase
        if (issue_fwd) begin
            front_d = 1'b1;
            if (limit_hit) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end else begin
                state_d = fwd_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= SEEK;
            resume_q <= 1'b0;
            front_q  <= 1'b0;
            turn_q   <= 1'b0;
            remove_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            front_q  <= front_d;
            turn_q   <= turn_d;
            remove_q <= remove_d;
            halted_q <= halted_d;
        end
    end

    assign front  = front_q;
    assign turn   = turn_q;
    assign remove = remove_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_robot_controller.sv
// Directed bench for robot_controller: main instance for behaviour, second instance (STEP_LIMIT=5) for the step limit.
module tb_robot_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rst2  = 1'b0;
    logic head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
    logic front, turn, remove, halted;
    logic front2, turn2, remove2, halted2;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    robot_controller #(.STEP_LIMIT(1000)) dut (
        .clock(clock), .reset(reset), .head(head), .left(left), .under(under), .barrier(barrier),
        .front(front), .turn(turn), .remove(remove), .halted(halted)
    );

    robot_controller #(.STEP_LIMIT(5)) dut_lim (
        .clock(clock), .reset(rst2), .head(1'b0), .left(1'b0), .under(1'b0), .barrier(1'b0),
        .front(front2), .turn(turn2), .remove(remove2), .halted(halted2)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b ({front,turn,remove,halted})", tag, got, exp);
        end
    endtask

    // s = {head,left,under,barrier}; e = {front,turn,remove,halted}
    task automatic step(input string tag, input logic [3:0] s, input logic [3:0] e);
        {head, left, under, barrier} = s;
        @(posedge clock); #1;
        chk(tag, {front, turn, remove, halted}, e);
    endtask

    task automatic do_reset(input string tag);
        {head, left, under, barrier} = 4'b0000;
        reset = 1'b0;
        #1;
        chk(tag, {front, turn, remove, halted}, 4'b0000);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clock);
        #1;
        chk("reset", {front, turn, remove, halted}, 4'b0000);
        reset = 1'b1;
        // Seek to wall
        step("seek_f0", 4'b0000, 4'b1000);
        step("seek_f1", 4'b0000, 4'b1000);
        step("seek_f2", 4'b0000, 4'b1000);
        step("seek_t0", 4'b1000, 4'b0100);
        step("seek_t1_under_ign", 4'b0010, 4'b0100);
        step("seek_t2", 4'b0000, 4'b0100);
        step("follow_f", 4'b0100, 4'b1000);
        // Corner
        step("corner_t", 4'b0000, 4'b0100);
        step("corner_force", 4'b0000, 4'b1000);
        step("corner_follow", 4'b0100, 4'b1000);
        // Trash in FOLLOW
        step("trash_r0", 4'b0101, 4'b0010);
        step("trash_r1_under_ign", 4'b0011, 4'b0010);
        step("trash_r2", 4'b0100, 4'b0010);
        step("trash_resume_follow", 4'b0000, 4'b0100);
        step("trash_after_force", 4'b0100, 4'b1000);
        // Trash from SEEK
        do_reset("rst_mid");
        step("seek_trash_r0", 4'b0001, 4'b0010);
        step("seek_trash_r1", 4'b0000, 4'b0010);
        step("seek_trash_r2", 4'b0000, 4'b0010);
        step("seek_trash_resume", 4'b0000, 4'b1000);
        // Reset mid-rotation aborts it
        step("abort_t0", 4'b1000, 4'b0100);
        do_reset("rst_in_rot");
        step("abort_seek", 4'b0000, 4'b1000);
        // Exit
        step("exit_t0", 4'b1000, 4'b0100);
        step("exit_t1", 4'b0000, 4'b0100);
        step("exit_t2", 4'b0000, 4'b0100);
        step("exit_halt", 4'b0110, 4'b0001);
        for (int i = 0; i < 10; i++)
            step("halt_sticky", 4'($urandom_range(0, 15)), 4'b0001);
        do_reset("halt_clr");
        step("post_halt_seek", 4'b0000, 4'b1000);
        // Step limit (second instance, sensors tied open)
        @(posedge clock); #1;
        rst2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
`ifdef ROBOT_STEP_LIMIT_EN
            chk("step_limit", {front2, turn2, remove2, halted2}, {(i < 5), 1'b0, 1'b0, (i >= 4)});
`else
            chk("no_step_limit", {front2, turn2, remove2, halted2}, 4'b1000);
`endif
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
